// File: rtl/fir_mac_filter_pkg.sv
// Shared definitions for the sequential single-multiplier FIR filter:
// FSM state encoding, default coefficient value and a constant clog2 helper.
package fir_mac_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // 0.125 in Q1.17
    localparam int COEF_DEFAULT = 16384;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_filter_coef_rom.sv
// Combinational coefficient lookup: tap index k selects coef[k] from a flat
// NTAPS*COEF_W vector, tap 0 in the least significant slice.
module fir_coef_rom
    import fir_mac_filter_pkg::*;
#(
    parameter int                         COEF_W = 18,
    parameter int                         NTAPS  = 8,
    parameter logic [NTAPS*COEF_W-1:0]    COEFS  = {NTAPS{COEF_W'(COEF_DEFAULT)}},
    localparam int                        KW     = clog2(NTAPS)
) (
    input  logic        [KW-1:0]     k,
    output logic signed [COEF_W-1:0] coef
);

    logic signed [COEF_W-1:0] coef_tbl [NTAPS];

    for (genvar g = 0; g < NTAPS; g++) begin : g_tbl
        assign coef_tbl[g] = COEFS[g*COEF_W +: COEF_W];
    end

    assign coef = coef_tbl[k];

endmodule

// File: rtl/fir_mac_filter.sv
// Sequential FIR: one sample accepted per handshake, NTAPS multiply-accumulates
// (one per cycle), then a rounded and saturated result held until taken.
module fir_mac_filter
    import fir_mac_filter_pkg::*;
#(
    parameter int                         DATA_W = 24,
    parameter int                         COEF_W = 18,
    parameter int                         NTAPS  = 8,
    parameter int                         OUT_W  = 24,
    parameter logic [NTAPS*COEF_W-1:0]    COEFS  = {NTAPS{COEF_W'(COEF_DEFAULT)}}
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] iv_din,
    input  logic                     i_din_valid,
    output logic                     o_ready,
    output logic signed [OUT_W-1:0]  ov_dout,
    output logic                     o_dout_valid,
    input  logic                     i_dout_ready,
    output logic                     o_sat
);

    localparam int KW     = clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + clog2(NTAPS);

    localparam logic        [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic        [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   MAX_V   = (ACC_W+1)'($signed(OUT_MAX));
    localparam logic signed [ACC_W:0]   MIN_V   = (ACC_W+1)'($signed(OUT_MIN));
    localparam logic signed [ACC_W:0]   RND     = (ACC_W+1)'(1) << (COEF_W - 2);

    fir_state_t               state;
    logic signed [DATA_W-1:0] taps [NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic        [KW-1:0]     k;

    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic        [OUT_W:0]    sat_res;

    // Round half up at the Q1.(COEF_W-1) binary point, then drop the fraction.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = (ACC_W+1)'(a) + RND;
        return t >>> (COEF_W - 1);
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] v);
        if (v > MAX_V)
            return {1'b1, OUT_MAX};
        else if (v < MIN_V)
            return {1'b1, OUT_MIN};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    fir_coef_rom #(
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .COEFS  (COEFS)
    ) u_coef_rom (
        .k    (k),
        .coef (coef)
    );

    assign prod    = taps[k] * coef;
    assign sum     = acc + ACC_W'(prod);
    assign sat_res = saturate(round_shift(sum));
    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            taps         <= '{default: '0};
            acc          <= '0;
            k            <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            o_sat        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_din_valid) begin
                        taps[0] <= iv_din;
                        for (int i = 1; i < NTAPS; i++)
                            taps[i] <= taps[i-1];
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    k   <= k + 1'b1;
                    if (k == KW'(NTAPS - 1)) begin
                        {o_sat, ov_dout} <= sat_res;
                        o_dout_valid     <= 1'b1;
                        state            <= OUT;
                    end
                end
                OUT: begin
                    if (i_dout_ready) begin
                        o_dout_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench: default-coefficient filter and an all-0.25 filter driven by
// the same stimulus, expected values worked out by hand for each step.
module tb_fir_mac_filter;

    logic               clk;
    logic               rst_n;
    logic signed [23:0] din;
    logic               din_valid;
    logic               dout_ready;

    logic               ready_a, valid_a, sat_a;
    logic signed [23:0] dout_a;
    logic               ready_b, valid_b, sat_b;
    logic signed [23:0] dout_b;

    int checks = 0;
    int errors = 0;

    fir_mac_filter u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_ready      (ready_a),
        .ov_dout      (dout_a),
        .o_dout_valid (valid_a),
        .i_dout_ready (dout_ready),
        .o_sat        (sat_a)
    );

    fir_mac_filter #(
        .COEFS ({8{18'sd32768}})
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_ready      (ready_b),
        .ov_dout      (dout_b),
        .o_dout_valid (valid_b),
        .i_dout_ready (dout_ready),
        .o_sat        (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts and ends on a negedge; lat counts edges from accept to valid.
    task automatic xfer(input logic signed [23:0] d,
                        output logic signed [23:0] qa, output logic sa,
                        output logic signed [23:0] qb, output logic sb,
                        output int lat);
        int n;
        n = 0;
        while (!ready_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        lat = 0;
        while (!valid_a && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        qa = dout_a;
        sa = sat_a;
        qb = dout_b;
        sb = sat_b;
        @(negedge clk);
    endtask

    int exp_a_pos [8] = '{1048576, 2097152, 3145728, 4194304,
                          5242879, 6291455, 7340031, 8388607};
    int exp_b_pos [8] = '{2097152, 4194304, 6291455, 8388607,
                          8388607, 8388607, 8388607, 8388607};
    int sat_b_pos [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    logic signed [23:0] words   [4] = '{24'sd65536, 24'sd131072, 24'sd0, -24'sd65536};
    int                 exp_b2b [4] = '{8192, 24576, 24576, 16384};

    initial begin
        logic signed [23:0] qa, qb, pre_q;
        logic               sa, sb, pre_rdy, pre_vld;
        int                 lat, acc_cnt, out_cnt;
        logic signed [23:0] outs [8];

        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", dout_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_dout_b", dout_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready_a, 1);
        check("rst_ready_b", ready_b, 1);

        // Impulse response
        xfer(24'sd65536, qa, sa, qb, sb, lat);
        check("imp_out0", qa, 8192);
        check("imp_lat0", lat, 8);
        for (int i = 1; i <= 8; i++) begin
            xfer(24'sd0, qa, sa, qb, sb, lat);
            check($sformatf("imp_out%0d", i), qa, (i < 8) ? 8192 : 0);
            check($sformatf("imp_lat%0d", i), lat, 8);
        end

        // Positive full-scale DC: ramp on A, clipping from the 5th sample on B
        for (int i = 0; i < 8; i++) begin
            xfer(24'sh7FFFFF, qa, sa, qb, sb, lat);
            check($sformatf("dcp_a%0d", i), qa, exp_a_pos[i]);
            check($sformatf("dcp_a_sat%0d", i), sa, 0);
            check($sformatf("dcp_b%0d", i), qb, exp_b_pos[i]);
            check($sformatf("dcp_b_sat%0d", i), sb, sat_b_pos[i]);
        end

        // Negative full-scale DC replacing the positive history
        for (int i = 0; i < 8; i++) begin
            xfer(24'sh800000, qa, sa, qb, sb, lat);
            if (i == 3) begin
                check("dcn_a_mid", qa, 0);
                check("dcn_b_mid", qb, -1);
                check("dcn_b_mid_sat", sb, 0);
            end
        end
        check("dcn_a_end", qa, -8388608);
        check("dcn_a_end_sat", sa, 0);
        check("dcn_b_end", qb, -8388608);
        check("dcn_b_end_sat", sb, 1);

        // Backpressure: output held, samples offered in OUT are not consumed
        do_reset();
        dout_ready = 1'b0;
        xfer(24'sd65536, qa, sa, qb, sb, lat);
        check("bp_first", qa, 8192);
        for (int i = 0; i < 5; i++) begin
            din       = 24'sd1048576;
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d", i), dout_a, 8192);
            check($sformatf("bp_valid%0d", i), valid_a, 1);
            check($sformatf("bp_ready%0d", i), ready_a, 0);
            @(negedge clk);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        xfer(24'sd131072, qa, sa, qb, sb, lat);
        check("bp_next", qa, 24576);

        // Asynchronous reset while the MAC is at k=3
        while (!ready_a) @(negedge clk);
        din       = 24'sh7FFFFF;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dout", dout_a, 0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_ready", ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(24'sd65536, qa, sa, qb, sb, lat);
        check("post_rst_imp0", qa, 8192);
        xfer(24'sd0, qa, sa, qb, sb, lat);
        check("post_rst_imp1", qa, 8192);

        // Streaming source holding valid high: one output per accepted word
        do_reset();
        acc_cnt   = 0;
        out_cnt   = 0;
        din       = words[0];
        din_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            pre_rdy = ready_a;
            pre_vld = valid_a;
            pre_q   = dout_a;
            @(posedge clk);
            #1;
            if (pre_rdy && din_valid) begin
                acc_cnt++;
                if (acc_cnt < 4)
                    din = words[acc_cnt];
                else
                    din_valid = 1'b0;
            end
            if (pre_vld) begin
                if (out_cnt < 8)
                    outs[out_cnt] = pre_q;
                out_cnt++;
            end
            @(negedge clk);
        end
        check("b2b_accepts", acc_cnt, 4);
        check("b2b_outputs", out_cnt, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_out%0d", i), outs[i], exp_b2b[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
